// File: rtl/ps2_key_sequencer_pkg.sv
// Shared scan-code constants, sequencer state encoding and case helper
// for the PS/2 key sequencer slice.
package ps2_key_sequencer_pkg;

  localparam logic [7:0] SC_BREAK       = 8'hF0;
  localparam logic [7:0] SC_EXT         = 8'hE0;
  localparam logic [7:0] SC_LSHIFT      = 8'h12;
  localparam logic [7:0] SC_RSHIFT      = 8'h59;
  localparam logic [7:0] SC_CAPS        = 8'h58;
  localparam logic [7:0] ASCII_UNMAPPED = 8'h2A;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } seq_state_t;

  // Lookup table yields upper-case letters; fold down unless exactly
  // one of shift/caps is active.
  function automatic logic [7:0] fold_case(
    input logic [7:0] a,
    input logic       upper
  );
    logic letter;
    letter = (a >= 8'h41) && (a <= 8'h5A);
    if (letter && !upper) return a + 8'h20;
    return a;
  endfunction

endpackage

// File: rtl/ps2_key_sequencer_fifo.sv
// Show-ahead character FIFO; a pop frees a slot for a same-cycle push
// when full. Overflow tracking is left to the caller.
module ps2_char_fifo
  import ps2_key_sequencer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] wr_data,
  input  logic       rd,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_rd;
  logic          do_wr;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_FULL);
  assign do_rd   = rd && !empty;
  assign do_wr   = wr && (!full || do_rd);
  assign rd_data = empty ? 8'h00 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + PTR_ONE;
      if (do_rd) rptr <= rptr + PTR_ONE;
      unique case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// Scan-code decoder with shift/caps tracking, ASCII lookup sequencing
// and a character FIFO for the bus slave.
module ps2_key_sequencer
  import ps2_key_sequencer_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int DROP_UNMAPPED = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic [7:0] ps2_code,
  input  logic [7:0] ascii_code,
  input  logic       rd,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  input  logic       clr_overflow,
  output logic       caps_led
);

  seq_state_t state, state_d;
  logic       shift, shift_d;
  logic       caps, caps_d;
  logic [7:0] code_d;
  logic       arm, arm_d;
  logic       is_shift;
  logic       wr_char;
  logic [7:0] char_d;

  assign is_shift = (rx_data == SC_LSHIFT) ||
                    (rx_data == SC_RSHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      shift    <= 1'b0;
      caps     <= 1'b0;
      ps2_code <= 8'h00;
      arm      <= 1'b0;
    end else begin
      state    <= state_d;
      shift    <= shift_d;
      caps     <= caps_d;
      ps2_code <= code_d;
      arm      <= arm_d;
    end
  end

  always_comb begin
    state_d = state;
    shift_d = shift;
    caps_d  = caps;
    code_d  = ps2_code;
    arm_d   = 1'b0;
    if (rx_done_tick) begin
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            (rx_data == SC_BREAK): state_d = S_BRK;
            (rx_data == SC_EXT):   state_d = S_EXT;
            is_shift:              shift_d = 1'b1;
            (rx_data == SC_CAPS):  caps_d  = ~caps;
            default: begin
              code_d = rx_data;
              arm_d  = 1'b1;
            end
          endcase
        end
        S_BRK: begin
          if (is_shift) shift_d = 1'b0;
          state_d = S_IDLE;
        end
        S_EXT: begin
          state_d = (rx_data == SC_BREAK) ? S_EXT_BRK : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Lookup settles during the cycle after ps2_code loads.
  assign char_d  = fold_case(ascii_code, shift ^ caps);
  assign wr_char = arm &&
                   !((DROP_UNMAPPED != 0) &&
                     (ascii_code == ASCII_UNMAPPED));

  always_ff @(posedge clk) begin
    if (reset)
      overflow <= 1'b0;
    else if (clr_overflow)
      overflow <= 1'b0;
    else if (wr_char && full && !rd)
      overflow <= 1'b1;
  end

  assign caps_led = caps;

  ps2_char_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr_char),
    .wr_data(char_d),
    .rd     (rd),
    .rd_data(rd_data),
    .empty  (empty),
    .full   (full)
  );

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer with an attached scan-code lookup
// model; expected characters are hand-computed.
module tb_ps2_key_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] ps2_code;
  logic [7:0] ascii_code;
  logic       rd = 1'b0;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       clr_overflow = 1'b0;
  logic       caps_led;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ps2_key_sequencer #(
    .DEPTH(16),
    .DROP_UNMAPPED(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data),
    .ps2_code    (ps2_code),
    .ascii_code  (ascii_code),
    .rd          (rd),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .clr_overflow(clr_overflow),
    .caps_led    (caps_led)
  );

  function automatic logic [7:0] lookup(input logic [7:0] c);
    case (c)
      8'h1C: return 8'h41;
      8'h32: return 8'h42;
      8'h21: return 8'h43;
      8'h23: return 8'h44;
      8'h24: return 8'h45;
      8'h2B: return 8'h46;
      8'h34: return 8'h47;
      8'h33: return 8'h48;
      8'h43: return 8'h49;
      8'h3B: return 8'h4A;
      8'h42: return 8'h4B;
      8'h4B: return 8'h4C;
      8'h3A: return 8'h4D;
      8'h31: return 8'h4E;
      8'h44: return 8'h4F;
      8'h4D: return 8'h50;
      8'h16: return 8'h31;
      8'h29: return 8'h20;
      default: return 8'h2A;
    endcase
  endfunction

  always_comb ascii_code = lookup(ps2_code);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check({tag, "_empty"}, empty, 1'b0);
    check(tag, rd_data, exp);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] fill_codes [17];
  logic [7:0] fill_exp [16];

  initial begin
    fill_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
                   8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B,
                   8'h3A, 8'h31, 8'h44, 8'h4D, 8'h16};
    fill_exp = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66,
                 8'h67, 8'h68, 8'h69, 8'h6A, 8'h6B, 8'h6C,
                 8'h6D, 8'h6E, 8'h6F, 8'h70};

    repeat (2) @(negedge clk);
    check("rst_code", ps2_code, 8'h00);
    check("rst_rdata", rd_data, 8'h00);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_caps", caps_led, 1'b0);
    reset = 1'b0;

    // plain make then break, check 2-clock latency
    @(negedge clk);
    rx_data = 8'h1C;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    check("lat_code", ps2_code, 8'h1C);
    check("lat_empty1", empty, 1'b1);
    @(negedge clk);
    check("lat_empty2", empty, 1'b0);
    send(8'hF0); send(8'h1C);
    settle();
    pop("a_plain", 8'h61);
    @(negedge clk);
    check("a_drained", empty, 1'b1);

    // shift make/break and digit under shift
    send(8'h12); send(8'h1C);
    send(8'hF0); send(8'h12);
    send(8'h1C);
    send(8'h12); send(8'h16);
    settle();
    pop("shift_A", 8'h41);
    pop("noshift_a", 8'h61);
    pop("shift_1", 8'h31);
    @(negedge clk);
    check("shift_drained", empty, 1'b1);

    // caps lock, then caps plus shift
    do_reset();
    send(8'h58); send(8'hF0); send(8'h58);
    send(8'h1C);
    settle();
    check("caps_led", caps_led, 1'b1);
    pop("caps_A", 8'h41);
    send(8'h12); send(8'h1C);
    settle();
    pop("caps_shift_a", 8'h61);

    // extended make/break ignored, space queued, unmapped dropped
    do_reset();
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h29);
    settle();
    pop("ext_space", 8'h20);
    @(negedge clk);
    check("ext_only_one", empty, 1'b1);
    send(8'h07);
    settle();
    check("unmapped_drop", empty, 1'b1);

    // fill past DEPTH, back-to-back ticks
    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rx_data = fill_codes[i];
      rx_done_tick = 1'b1;
    end
    @(negedge clk);
    rx_done_tick = 1'b0;
    settle();
    check("fill_full", full, 1'b1);
    check("fill_ovf", overflow, 1'b1);
    @(negedge clk);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("clr_ovf", overflow, 1'b0);

    // rd coincides with push while full
    @(negedge clk);
    rx_data = 8'h29;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("rdpush_full", full, 1'b1);
    check("rdpush_ovf", overflow, 1'b0);
    for (int i = 1; i < 16; i++)
      pop($sformatf("fill_%0d", i), fill_exp[i]);
    pop("fill_space", 8'h20);
    @(negedge clk);
    check("fill_drained", empty, 1'b1);

    // reset after E0 prefix with caps active
    do_reset();
    send(8'h58);
    send(8'hE0);
    do_reset();
    check("rst_mid_caps", caps_led, 1'b0);
    check("rst_mid_empty", empty, 1'b1);
    send(8'h1C);
    settle();
    pop("rst_mid_a", 8'h61);

    // reset with shift held and a push in flight
    send(8'h12);
    @(negedge clk);
    rx_data = 8'h1C;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_push_empty", empty, 1'b1);
    send(8'h1C);
    settle();
    pop("rst_shift_a", 8'h61);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
